regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port general-purpose register file with an integrated per-register pending-write scoreboard, for the decode/writeback boundary of the pipelined CPU core. Decode reads operands through NUM_RD combinational ports. Each read port reports whether its value is final. Decode also marks destination registers as pending at issue. Writeback retires results through NUM_WR write ports with same-cycle forwarding. This replaces the fixed 2-read/1-write register file and gives the hazard unit a single source of operand readiness.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- NUM_RD, 2, read ports
- NUM_WR, 2, write ports; a higher index has higher priority
- CNT_W, 2, pending-counter width; max outstanding writes per register = 2**CNT_W-1
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  reset; asynchronous, active-low
- raddr  in  NUM_RD*ADDR_W  read indices, port i at [i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  read data
- rvalid  out  NUM_RD  per port: value final, not awaiting a pending write
- we  in  NUM_WR  write enables
- wrel  in  NUM_WR  write also releases one pending count; ignored when we=0
- waddr  in  NUM_WR*ADDR_W  write indices
- wdata  in  NUM_WR*DATA_W  write data
- iss_valid  in  1  mark iss_addr pending
- iss_addr  in  ADDR_W  destination being issued
- iss_ready  out  1  issue accepted this cycle when iss_valid=1
- flush  in  1  clear all pending counts; data is kept

## Operation
- Register 0: reads 0 and rvalid=1. Writes, issues and releases to it have no effect. iss_ready=1 for it.
- Write: on the edge, every port with we=1 and waddr≠0 updates its register. When ports share an address, the highest-index port wins.
- Read, combinational: if any write port has we=1 and a matching waddr≠0, return the highest-index matching wdata (bypass). Otherwise return the array value.
- Pending count per register cnt[r], 0..2**CNT_W-1. Per edge:
  - cnt_next = cnt + inc − dec.
  - inc = 1 when iss_valid & iss_ready & iss_addr=r.
  - dec = number of ports with we & wrel & waddr=r.
  - Result saturates at 0. An underflow attempt is legal: it is a release of an untracked write.
- Simultaneous issue and one release on the same r: cnt is unchanged.
- iss_ready = (iss_addr==0) | (cnt[iss_addr] < max). No lookahead on releases in the same cycle.
- rvalid[i] = (raddr==0) | (cnt[raddr]==0) | (cnt[raddr] − dec[raddr] ≤ 0 this cycle).
- flush: every cnt goes to 0 on the edge. flush dominates issue and release in the same cycle. Writes with we=1 still update data.
- Reset asserted, at any time including mid-operation: the array and all cnt go to 0 immediately.
- Outputs during reset:
  - rdata = 0 unless a bypass is active.
  - rvalid = all 1.
  - iss_ready = 1.

## Timing
- Read path, bypass and rvalid: 0 cycles, combinational.
- Write becomes visible from the array 1 cycle after the edge. Before that edge it is visible through bypass.
- Issue at edge N: rvalid for that register drops from cycle N+1 onward.
- Release at edge N with cnt reaching 0: rvalid=1 during cycle N, via the lookahead, and from then on.
- Flush: 1 cycle.

## Structure
- Put the shared constants in defines.vh: WriteEnable, default DATA_W/ADDR_W, and the zero-register index.
- Natural sub-module: regfile_sb_cnt. It is one saturating up/down pending counter with an inc, dec-count and flush input, instantiated 2**ADDR_W−1 times.
- Priority/bypass muxing is a generate loop in the top module.

## Test plan
- Reset then read r1..r31 -> rdata=0, rvalid=1.
- Write port 0 writes r5=0x1111 while port 1 writes r5=0x2222 at the same time -> read r5 shows 0x2222 on the bypass that cycle and from the array after the edge.
- Issue r7. Next cycle rvalid(r7)=0. Writeback with we=1, wrel=1, wdata=0xABCD -> that cycle rvalid=1 and rdata=0xABCD.
- Issue r3 three times with CNT_W=2 -> the fourth issue sees iss_ready=0. Three releases -> rvalid(r3)=1 only on the third.
- With cnt(r9)=2, apply flush plus an issue of r9 in the same cycle -> cnt(r9)=0. A data write of r9=0x55 in the same cycle is kept.
- Deassert resetn mid-stream with pending counts and data nonzero -> all outputs take their reset values asynchronously.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Purpose : shared constants and helpers for the regfile_sb register file.
// Contents: write-enable level, default widths, zero-register index and a
//           small max helper used to size internal arithmetic.
package regfile_sb_pkg;

  localparam logic WRITE_ENABLE = 1'b1;
  localparam int   DEF_DATA_W   = 32;
  localparam int   DEF_ADDR_W   = 5;
  localparam int   ZERO_REG     = 0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Purpose : bundle of the decode/writeback signals of regfile_sb.
// Ports   : raddr/rdata/rvalid  - NUM_RD combinational read ports
//           we/wrel/waddr/wdata - NUM_WR write ports (higher index wins)
//           iss_valid/iss_addr/iss_ready - destination issue handshake
//           flush               - clear all pending counts
// The master modport is the pipeline side, slave is the register file.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rvalid;
  logic [NUM_WR-1:0]        we;
  logic [NUM_WR-1:0]        wrel;
  logic [NUM_WR*ADDR_W-1:0] waddr;
  logic [NUM_WR*DATA_W-1:0] wdata;
  logic                     iss_valid;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     iss_ready;
  logic                     flush;

  modport master (
    output raddr, we, wrel, waddr, wdata, iss_valid, iss_addr, flush,
    input  rdata, rvalid, iss_ready
  );

  modport slave (
    input  raddr, we, wrel, waddr, wdata, iss_valid, iss_addr, flush,
    output rdata, rvalid, iss_ready
  );
endinterface

// File: rtl/regfile_sb_cnt.sv
// Purpose : one saturating up/down pending-write counter.
// Ports   : clk, resetn (async, active-low)
//           i_inc   - one new outstanding write this edge
//           i_dec   - number of writes retired this edge
//           i_flush - force the count to zero (dominates inc/dec)
//           o_cnt   - current pending count
module regfile_sb_cnt #(
  parameter int CNT_W = 2,
  parameter int DEC_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_inc,
  input  logic [DEC_W-1:0] i_dec,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_cnt
);
  import regfile_sb_pkg::*;

  // One spare bit so cnt+inc never wraps before the comparison.
  localparam int SUM_W = max_int(CNT_W, DEC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next;
  logic [SUM_W-1:0] w_up;
  logic [SUM_W-1:0] w_diff;

  always_comb begin
    w_up   = SUM_W'(r_cnt) + SUM_W'(i_inc);
    w_diff = w_up - SUM_W'(i_dec);
    w_next = r_cnt;
    if (i_flush) begin
      w_next = '0;
    end else if (w_up <= SUM_W'(i_dec)) begin
      // Releasing more than was tracked is legal: clamp at zero.
      w_next = '0;
    end else if (w_diff > SUM_W'(CNT_MAX)) begin
      w_next = CNT_MAX;
    end else begin
      w_next = w_diff[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_cnt <= '0;
    else         r_cnt <= w_next;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/regfile_sb.sv
// Purpose : multi-port register file with a per-register pending-write
//           scoreboard for the decode/writeback boundary.
// Ports   : clk    - clock, all state changes on the rising edge
//           resetn - asynchronous active-low reset (clears data and counts)
//           bus    - regfile_sb_if.slave: read ports with readiness,
//                    write/release ports, issue handshake and flush
// Register 0 is hardwired: reads 0, always ready, ignores writes/issues.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int CNT_W  = 2
) (
  input  logic         clk,
  input  logic         resetn,
  regfile_sb_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int DEC_W = $clog2(NUM_WR + 1);
  localparam int CMP_W = max_int(CNT_W, DEC_W);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] w_mem [DEPTH];
  logic [CNT_W-1:0]  w_cnt [DEPTH];

  assign w_mem[0] = '0;
  assign w_cnt[0] = '0;

  // No release lookahead: a full register stays blocked this cycle even if
  // a writeback is retiring it right now.
  assign bus.iss_ready = (bus.iss_addr == ZERO_A) ||
                         (w_cnt[bus.iss_addr] < CNT_MAX);

  // Per-register storage and pending counter.
  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_reg
    logic              w_hit;
    logic [DATA_W-1:0] w_data;
    logic [DEC_W-1:0]  w_dec;
    logic              w_inc;
    logic [DATA_W-1:0] r_data;

    // Ascending scan so the highest-index matching port is the one kept.
    always_comb begin
      w_hit  = 1'b0;
      w_data = '0;
      w_dec  = '0;
      for (int p = 0; p < NUM_WR; p++) begin
        if ((bus.we[p] == WRITE_ENABLE) &&
            (bus.waddr[p*ADDR_W +: ADDR_W] == ADDR_W'(gi))) begin
          w_hit  = 1'b1;
          w_data = bus.wdata[p*DATA_W +: DATA_W];
          if (bus.wrel[p]) w_dec = w_dec + DEC_W'(1);
        end
      end
    end

    assign w_inc = bus.iss_valid && bus.iss_ready &&
                   (bus.iss_addr == ADDR_W'(gi));

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)    r_data <= '0;
      else if (w_hit) r_data <= w_data;
    end

    assign w_mem[gi] = r_data;

    regfile_sb_cnt #(
      .CNT_W (CNT_W),
      .DEC_W (DEC_W)
    ) u_cnt (
      .clk     (clk),
      .resetn  (resetn),
      .i_inc   (w_inc),
      .i_dec   (w_dec),
      .i_flush (bus.flush),
      .o_cnt   (w_cnt[gi])
    );
  end

  // Read ports: same-cycle bypass from the write ports plus readiness with
  // lookahead on releases retiring the register in this very cycle.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_byp;
    logic [DATA_W-1:0] w_byp_data;
    logic [DEC_W-1:0]  w_dec;

    assign w_addr = bus.raddr[gi*ADDR_W +: ADDR_W];

    always_comb begin
      w_byp      = 1'b0;
      w_byp_data = '0;
      w_dec      = '0;
      for (int p = 0; p < NUM_WR; p++) begin
        if ((bus.we[p] == WRITE_ENABLE) && (w_addr != ZERO_A) &&
            (bus.waddr[p*ADDR_W +: ADDR_W] == w_addr)) begin
          w_byp      = 1'b1;
          w_byp_data = bus.wdata[p*DATA_W +: DATA_W];
          if (bus.wrel[p]) w_dec = w_dec + DEC_W'(1);
        end
      end
    end

    assign bus.rdata[gi*DATA_W +: DATA_W] =
      (w_addr == ZERO_A) ? '0 : (w_byp ? w_byp_data : w_mem[w_addr]);

    // cnt - dec <= 0 also covers cnt == 0.
    assign bus.rvalid[gi] = (w_addr == ZERO_A) ||
                            (CMP_W'(w_cnt[w_addr]) <= CMP_W'(w_dec));
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus pushes expected outputs computed
// from an array-based reference model; a negedge monitor pops and compares.
module tb_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic resetn;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .CNT_W(CW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 rdata, 1 rvalid, 2 iss_ready
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  // Reference model: plain arrays of data and outstanding-write counts.
  logic [31:0] m_mem [32];
  int          m_cnt [32];

  function automatic void model_clear();
    for (int r = 0; r < 32; r++) begin
      m_mem[r] = '0;
      m_cnt[r] = 0;
    end
  endfunction

  function automatic int waddr_of(input int p);
    logic [NW*AW-1:0] v;
    v = bus.waddr;
    return int'(v[p*AW +: AW]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end else begin
      $display("ok   %s @%0t: %h", nm, $time, act);
    end
  endtask

  function automatic void push_expect();
    exp_t e;
    int   a;
    int   ndec;
    logic [31:0] d;
    logic [NR*AW-1:0] ra;
    logic [NW*DW-1:0] wd;
    ra = bus.raddr;
    wd = bus.wdata;
    for (int i = 0; i < NR; i++) begin
      a    = int'(ra[i*AW +: AW]);
      d    = m_mem[a];
      ndec = 0;
      for (int p = 0; p < NW; p++) begin
        if (bus.we[p] && a != 0 && waddr_of(p) == a) begin
          d = wd[p*DW +: DW];
          if (bus.wrel[p]) ndec++;
        end
      end
      if (a == 0) d = '0;
      e.kind = 0; e.port = i; e.exp = d;
      sb_q.push_back(e);
      e.kind = 1; e.port = i;
      e.exp = ((a == 0) || (m_cnt[a] - ndec <= 0)) ? 32'd1 : 32'd0;
      sb_q.push_back(e);
    end
    e.kind = 2; e.port = 0;
    e.exp = ((bus.iss_addr == '0) || (m_cnt[int'(bus.iss_addr)] < CMAX)) ? 32'd1 : 32'd0;
    sb_q.push_back(e);
  endfunction

  // Apply the rules of one clock edge to the model using the driven inputs.
  function automatic void model_commit();
    int inc [32];
    int dec [32];
    int ia;
    logic [NW*DW-1:0] wd;
    wd = bus.wdata;
    for (int r = 0; r < 32; r++) begin
      inc[r] = 0;
      dec[r] = 0;
    end
    ia = int'(bus.iss_addr);
    if (bus.iss_valid && ia != 0 && m_cnt[ia] < CMAX) inc[ia] = 1;
    for (int p = 0; p < NW; p++) begin
      if (bus.we[p] && waddr_of(p) != 0) begin
        m_mem[waddr_of(p)] = wd[p*DW +: DW];
        if (bus.wrel[p]) dec[waddr_of(p)]++;
      end
    end
    for (int r = 1; r < 32; r++) begin
      if (bus.flush) m_cnt[r] = 0;
      else begin
        m_cnt[r] = m_cnt[r] + inc[r] - dec[r];
        if (m_cnt[r] < 0) m_cnt[r] = 0;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    if (!resetn) model_clear();
    else         model_commit();
    #1;
  endtask

  task automatic set_idle();
    bus.raddr     = '0;
    bus.we        = '0;
    bus.wrel      = '0;
    bus.waddr     = '0;
    bus.wdata     = '0;
    bus.iss_valid = 1'b0;
    bus.iss_addr  = '0;
    bus.flush     = 1'b0;
  endtask

  task automatic rd(input int i, input int a);
    bus.raddr[i*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d, input logic rel);
    bus.we[p]             = 1'b1;
    bus.wrel[p]           = rel;
    bus.waddr[p*AW +: AW] = AW'(a);
    bus.wdata[p*DW +: DW] = d;
  endtask

  task automatic iss(input int a);
    bus.iss_valid = 1'b1;
    bus.iss_addr  = AW'(a);
  endtask

  // Monitor: compares everything queued for the current cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    string       nm;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        0:       begin act = bus.rdata[e.port*DW +: DW];  nm = "rdata";     end
        1:       begin act = {31'd0, bus.rvalid[e.port]}; nm = "rvalid";    end
        default: begin act = {31'd0, bus.iss_ready};      nm = "iss_ready"; end
      endcase
      n_vec++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s port%0d @%0t: got %h expected %h", nm, e.port, $time, act, e.exp);
      end
    end
  end

  // Watchdog: the run must complete within a bounded time.
  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog @%0t: test did not finish in time", $time);
    $finish;
  end

  initial begin
    model_clear();
    set_idle();
    resetn = 1'b0;
    rd(0, 4); rd(1, 17);
    push_expect();
    step();
    step();
    chk("reset rdata0",    bus.rdata[0*DW +: DW], 32'd0);
    chk("reset rdata1",    bus.rdata[1*DW +: DW], 32'd0);
    chk("reset rvalid",    {30'd0, bus.rvalid}, 32'd3);
    chk("reset iss_ready", {31'd0, bus.iss_ready}, 32'd1);
    resetn = 1'b1;

    // Reset state of every register through both read ports.
    for (int r = 1; r < 32; r++) begin
      set_idle();
      rd(0, r); rd(1, 32 - r);
      bus.iss_addr = AW'(r);
      push_expect();
      step();
    end

    // Same-address write on both ports: port 1 wins, bypass then array.
    set_idle();
    wr(0, 5, 32'h1111, 1'b0);
    wr(1, 5, 32'h2222, 1'b0);
    rd(0, 5); rd(1, 0);
    push_expect();
    step();
    set_idle();
    rd(0, 5); rd(1, 5);
    push_expect();
    step();

    // Issue r7, then retire it with release and bypassed data.
    set_idle();
    iss(7); rd(0, 7);
    push_expect();
    step();
    set_idle();
    rd(0, 7); rd(1, 7);
    push_expect();
    step();
    set_idle();
    wr(0, 7, 32'hABCD, 1'b1);
    rd(0, 7); rd(1, 7);
    push_expect();
    step();

    // Saturate r3: fourth issue refused, then three single releases.
    for (int k = 0; k < 4; k++) begin
      set_idle();
      iss(3); rd(0, 3);
      push_expect();
      step();
    end
    for (int k = 0; k < 3; k++) begin
      set_idle();
      wr(1, 3, 32'h300 + k, 1'b1);
      rd(0, 3); rd(1, 3);
      bus.iss_addr = AW'(3);
      push_expect();
      step();
    end

    // Flush dominates a same-cycle issue; the data write still lands.
    set_idle();
    iss(9);
    push_expect();
    step();
    set_idle();
    iss(9);
    push_expect();
    step();
    set_idle();
    iss(9); bus.flush = 1'b1;
    wr(0, 9, 32'h55, 1'b0);
    rd(0, 9);
    push_expect();
    step();
    set_idle();
    rd(0, 9); rd(1, 9);
    bus.iss_addr = AW'(9);
    push_expect();
    step();

    // Randomised traffic on a narrow address range to force collisions.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NR; i++) rd(i, $urandom_range(0, 7));
      for (int p = 0; p < NW; p++) begin
        bus.we[p]             = 1'($urandom_range(0, 1));
        bus.wrel[p]           = 1'($urandom_range(0, 1));
        bus.waddr[p*AW +: AW] = AW'($urandom_range(0, 7));
        bus.wdata[p*DW +: DW] = $urandom;
      end
      bus.iss_valid = ($urandom_range(0, 2) != 0);
      bus.iss_addr  = AW'($urandom_range(0, 7));
      bus.flush     = ($urandom_range(0, 29) == 0);
      push_expect();
      step();
    end

    // Load data and pending counts, then assert reset between edges.
    for (int r = 1; r < 8; r++) begin
      set_idle();
      wr(0, r, 32'hC0DE_0000 + r, 1'b0);
      iss(r);
      step();
    end
    set_idle();
    rd(0, 1); rd(1, 2);
    bus.iss_addr = AW'(1);
    resetn = 1'b0;
    model_clear();
    #1;
    chk("async rst rdata0",    bus.rdata[0*DW +: DW], 32'd0);
    chk("async rst rdata1",    bus.rdata[1*DW +: DW], 32'd0);
    chk("async rst rvalid",    {30'd0, bus.rvalid}, 32'd3);
    chk("async rst iss_ready", {31'd0, bus.iss_ready}, 32'd1);
    for (int r = 1; r < 8; r += 2) begin
      rd(0, r); rd(1, r + 1);
      bus.iss_addr = AW'(r);
      push_expect();
      #10;
    end
    #1;
    step();
    resetn = 1'b1;
    for (int r = 1; r < 8; r++) begin
      set_idle();
      rd(0, r); rd(1, 8 - r);
      bus.iss_addr = AW'(r);
      push_expect();
      step();
    end

    set_idle();
    @(negedge clk);
    #1;
    chk("queue drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
